// File: rtl/gpr_scoreboard_file.sv
// Multi-read-port GPR file with a per-register pending-write counter scoreboard.
// Readers see operand readiness for RAW stalls, with optional same-cycle write-back forwarding.
module gpr_scoreboard_file #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 64,
  parameter int NUM_RD     = 2,
  parameter int CNT_WIDTH  = 2,
  parameter bit BYPASS     = 1'b1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_RD*ADDR_WIDTH-1:0] rd_addr,
  output logic [NUM_RD*DATA_WIDTH-1:0] rd_data,
  output logic [NUM_RD-1:0]            rd_ready,
  input  logic                         alloc_valid,
  input  logic [ADDR_WIDTH-1:0]        alloc_addr,
  output logic                         alloc_ready,
  input  logic                         wb_valid,
  input  logic [ADDR_WIDTH-1:0]        wb_addr,
  input  logic [DATA_WIDTH-1:0]        wb_data,
  input  logic                         flush,
  output logic [(1<<ADDR_WIDTH)-1:0]   busy_mask
);

  localparam int NREG = 1 << ADDR_WIDTH;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  logic [DATA_WIDTH-1:0] data_q  [NREG];
  logic [CNT_WIDTH-1:0]  cnt_q   [NREG];
  logic [CNT_WIDTH-1:0]  cnt_nxt [NREG];

  // A write-back to the same register frees a slot in the cycle it arrives.
  always_comb begin
    alloc_ready = (alloc_addr == '0) || (cnt_q[alloc_addr] != CNT_MAX) ||
                  (wb_valid && (wb_addr == alloc_addr));
  end

  always_comb begin
    for (int r = 0; r < NREG; r++) begin
      logic inc;
      logic dec;
      inc = alloc_valid && alloc_ready && (alloc_addr == ADDR_WIDTH'(r)) && (r != 0);
      dec = wb_valid && (wb_addr == ADDR_WIDTH'(r)) && (cnt_q[r] != '0);
      cnt_nxt[r] = cnt_q[r];
      if (flush)
        cnt_nxt[r] = '0;
      else if (inc && !dec)
        cnt_nxt[r] = cnt_q[r] + CNT_WIDTH'(1);
      else if (dec && !inc)
        cnt_nxt[r] = cnt_q[r] - CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < NREG; r++) begin
        data_q[r] <= '0;
        cnt_q[r]  <= '0;
      end
    end else begin
      if (wb_valid && (wb_addr != '0))
        data_q[wb_addr] <= wb_data;
      for (int r = 0; r < NREG; r++)
        cnt_q[r] <= cnt_nxt[r];
    end
  end

  // A forwarded write-back only clears the stall if it is the last one outstanding.
  always_comb begin
    for (int i = 0; i < NUM_RD; i++) begin
      logic [ADDR_WIDTH-1:0] a;
      logic                  hit;
      a   = rd_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
      hit = BYPASS && wb_valid && (wb_addr == a) && (a != '0);
      if (a == '0)
        rd_data[i*DATA_WIDTH +: DATA_WIDTH] = '0;
      else if (hit)
        rd_data[i*DATA_WIDTH +: DATA_WIDTH] = wb_data;
      else
        rd_data[i*DATA_WIDTH +: DATA_WIDTH] = data_q[a];
      rd_ready[i] = (a == '0) || (cnt_q[a] == '0) ||
                    (hit && (cnt_q[a] == CNT_WIDTH'(1)));
    end
  end

  always_comb begin
    for (int r = 0; r < NREG; r++)
      busy_mask[r] = (cnt_q[r] != '0);
  end

endmodule

// File: doc/gpr_scoreboard_file.md
# gpr_scoreboard_file

Parametrised general-purpose register file for the NPC core with N read ports, one write-back port and a per-register pending-write scoreboard. The issue stage allocates destination registers, and write-back retires them. Read ports report operand readiness so the pipeline can stall on RAW hazards, with optional same-cycle write-back bypass. The block sits between decode/issue (reads, allocation) and write-back (writes), and replaces the single-issue two-port register file.

## Interface
- ADDR_WIDTH, 5, register index width; register count is 2^ADDR_WIDTH
- DATA_WIDTH, 64, register width
- NUM_RD, 2, number of read ports (1..4)
- CNT_WIDTH, 2, width of each pending-write counter; at most 2^CNT_WIDTH-1 outstanding writes per register
- BYPASS, 1, 1 = forward same-cycle write-back data to read ports; 0 = no forwarding
- clk  input  1  single clock; all state updates on posedge
- rst  input  1  asynchronous, active-low reset
- rd_addr  input  NUM_RD*ADDR_WIDTH  read indices; port i is bits [i*ADDR_WIDTH +: ADDR_WIDTH]
- rd_data  output  NUM_RD*DATA_WIDTH  read data, combinational
- rd_ready  output  NUM_RD  1 = operand on port i is valid this cycle
- alloc_valid  input  1  issue stage requests a pending write to alloc_addr
- alloc_addr  input  ADDR_WIDTH  destination being allocated
- alloc_ready  output  1  allocation accepted this cycle when alloc_valid & alloc_ready
- wb_valid  input  1  write-back strobe
- wb_addr  input  ADDR_WIDTH  write-back destination
- wb_data  input  DATA_WIDTH  write-back value
- flush  input  1  clear all pending counters (pipeline squash)
- busy_mask  output  2^ADDR_WIDTH  bit r = 1 when counter[r] != 0

## Operation
- Storage: 2^ADDR_WIDTH data registers plus one CNT_WIDTH counter per register.
- x0: reads always return 0 with ready=1. Writes and allocations to x0 are ignored; alloc_ready=1 for x0 allocations.
- Write: if wb_valid and wb_addr!=0, data[wb_addr] <= wb_data at posedge.
- Counter update per register r, at posedge:
  - inc = alloc_valid & alloc_ready & alloc_addr==r & r!=0
  - dec = wb_valid & wb_addr==r & counter[r]!=0
  - inc & dec: unchanged; inc only: +1; dec only: -1.
  - A write-back to a register with counter 0 still writes data and leaves the counter at 0 (no underflow).
- flush: all counters <= 0 at posedge, overriding inc/dec. A concurrent wb data write still occurs. A concurrent alloc is dropped.
- alloc_ready = (alloc_addr==0) | (counter[alloc_addr] != 2^CNT_WIDTH-1) | (wb_valid & wb_addr==alloc_addr). Write-back frees a slot in the same cycle. alloc_ready does not depend on alloc_valid.
- Read port i, with a = rd_addr[i]:
  - hit = BYPASS & wb_valid & wb_addr==a & a!=0
  - rd_data[i] = a==0 ? 0 : hit ? wb_data : data[a]
  - rd_ready[i] = a==0 | counter[a]==0 | (hit & counter[a]==1)
- Same-cycle allocation of a does not lower rd_ready for a. The reader is older than the allocating instruction.

## Timing
- Reset (rst low, async): all data registers 0 and all counters 0. Outputs settle to rd_data=0, rd_ready=all 1, alloc_ready=1, busy_mask=0. Reset asserted mid-operation discards pending counts and data immediately. Release is synchronous to the next posedge.
- Read latency: 0 cycles (combinational).
- Write latency: data visible on rd_data in the cycle after wb_valid, or in the same cycle when BYPASS=1.
- Counter/busy_mask latency: 1 cycle after alloc/wb/flush.
- Handshake: allocation completes on any posedge where alloc_valid & alloc_ready. Write-back has no backpressure.
- Saturation: when counter = 2^CNT_WIDTH-1 and there is no same-cycle wb to that register, alloc_ready=0 and the counter holds.

## Test plan
- Reset: drive rst low mid-run after writing x5=0xDEAD, release -> rd_data for x5 = 0, rd_ready=1, busy_mask=0.
- x0 guard: wb x0=0xFFFF and alloc x0 -> read x0 returns 0, ready=1, busy_mask[0]=0.
- RAW stall: alloc x3; next cycle read x3 -> ready=0. Then wb x3=0x42 with BYPASS=1 -> same cycle ready=1, data=0x42. Next cycle counter=0.
- Multiple outstanding: alloc x7 three times (CNT_WIDTH=2) -> 4th alloc_ready=0. Then alloc+wb x7 in the same cycle -> accepted, counter stays 3. Two more wb -> counter 1, read ready=0 until the final wb.
- Flush: alloc x1, x2; flush with concurrent wb x2=0x9 -> busy_mask=0 next cycle, x2 reads 0x9, x1 ready=1.
- BYPASS=0 build: wb x4=0x11 with concurrent read x4 -> old value returned and ready as per counter. Next cycle -> 0x11.
